// File: rtl/bus_cycle_sequencer.sv
// External bus cycle sequencer: setup / strobe / wait-stretch / hold timing for
// CPU bus cycles, plus hand-over of the pins to an external DMA master.
module bus_cycle_sequencer #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_mem_io,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_halt,
    input  logic        dma_req,
    input  logic        pin_wait,
    input  logic [7:0]  data_bus_in,
    output logic [21:0] address_bus,
    output logic        mem_io,
    output logic        rd_n,
    output logic        wr_n,
    output logic [7:0]  data_bus_out,
    output logic        data_oe,
    output logic        addr_oe,
    output logic        dma_ack,
    output logic [7:0]  rdata,
    output logic        cpu_done,
    output logic        bus_err
);
    localparam int SETUP_W  = (SETUP_CYCLES  > 1) ? $clog2(SETUP_CYCLES)  : 1;
    localparam int STROBE_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    // Phase counters run 0..N-1, so the last value marks the final cycle of a phase.
    localparam logic [SETUP_W-1:0]  SETUP_LAST  = SETUP_W'(SETUP_CYCLES - 1);
    localparam logic [STROBE_W-1:0] STROBE_LAST = STROBE_W'(STROBE_CYCLES - 1);
    localparam logic [7:0]          WAIT_LAST   = 8'(WAIT_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DMA    = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [SETUP_W-1:0]  setup_cnt_r;
    logic [STROBE_W-1:0] strobe_cnt_r;
    logic [7:0]          wait_cnt_r;
    logic                wr_r;
    logic                accept_s;
    logic                leave_s;
    logic                timeout_s;

    logic [21:0] addr_nx_s;
    logic        mem_io_nx_s;
    logic [7:0]  dout_nx_s;
    logic        wr_nx_s;
    logic [7:0]  rdata_nx_s;
    logic        rd_n_nx_s;
    logic        wr_n_nx_s;
    logic        data_oe_nx_s;
    logic        addr_oe_nx_s;
    logic        dma_ack_nx_s;
    logic        done_nx_s;
    logic        err_nx_s;

    // State register.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; DMA wins over a simultaneous CPU request in IDLE only.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        leave_s    = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dma_req) begin
                    state_nx_s = ST_DMA;
                end else if (cpu_req) begin
                    state_nx_s = ST_SETUP;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_r == SETUP_LAST) begin
                    state_nx_s = ST_STROBE;
                end else begin
                    state_nx_s = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (strobe_cnt_r != STROBE_LAST) begin
                    state_nx_s = ST_STROBE;
                end else if (!pin_wait) begin
                    state_nx_s = ST_HOLD;
                    leave_s    = 1'b1;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nx_s = ST_HOLD;
                    leave_s    = 1'b1;
                    timeout_s  = 1'b1;
                end else begin
                    state_nx_s = ST_STROBE;
                end
            end
            ST_HOLD: state_nx_s = ST_IDLE;
            ST_DMA: begin
                if (dma_req) begin
                    state_nx_s = ST_DMA;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Saturating phase counters; each is held at zero outside its own phase.
    always_ff @(posedge clk) begin
        if (arst) begin
            setup_cnt_r  <= '0;
            strobe_cnt_r <= '0;
            wait_cnt_r   <= 8'd0;
        end else begin
            if (state_r != ST_SETUP) begin
                setup_cnt_r <= '0;
            end else if (setup_cnt_r != SETUP_LAST) begin
                setup_cnt_r <= setup_cnt_r + SETUP_W'(1);
            end else begin
                setup_cnt_r <= setup_cnt_r;
            end
            if (state_r != ST_STROBE) begin
                strobe_cnt_r <= '0;
                wait_cnt_r   <= 8'd0;
            end else if (strobe_cnt_r != STROBE_LAST) begin
                strobe_cnt_r <= strobe_cnt_r + STROBE_W'(1);
                wait_cnt_r   <= wait_cnt_r;
            end else if (pin_wait && (wait_cnt_r != WAIT_LAST)) begin
                strobe_cnt_r <= strobe_cnt_r;
                wait_cnt_r   <= wait_cnt_r + 8'd1;
            end else begin
                strobe_cnt_r <= strobe_cnt_r;
                wait_cnt_r   <= wait_cnt_r;
            end
        end
    end

    // Output decode from the upcoming state so every pin comes straight off a flop.
    always_comb begin
        rd_n_nx_s    = 1'b1;
        wr_n_nx_s    = 1'b1;
        data_oe_nx_s = 1'b0;
        addr_oe_nx_s = 1'b1;
        dma_ack_nx_s = 1'b0;
        done_nx_s    = 1'b0;
        err_nx_s     = 1'b0;
        if (accept_s) begin
            addr_nx_s   = cpu_addr;
            mem_io_nx_s = cpu_mem_io;
            dout_nx_s   = cpu_wdata;
            wr_nx_s     = cpu_wr;
        end else begin
            addr_nx_s   = address_bus;
            mem_io_nx_s = mem_io;
            dout_nx_s   = data_bus_out;
            wr_nx_s     = wr_r;
        end
        if (leave_s && !wr_r) begin
            rdata_nx_s = timeout_s ? 8'hFF : data_bus_in;
        end else begin
            rdata_nx_s = rdata;
        end
        case (state_nx_s)
            ST_IDLE:  addr_oe_nx_s = ~cpu_halt;
            ST_SETUP: data_oe_nx_s = wr_nx_s;
            ST_STROBE: begin
                data_oe_nx_s = wr_nx_s;
                rd_n_nx_s    = wr_nx_s;
                wr_n_nx_s    = ~wr_nx_s;
            end
            ST_HOLD: begin
                data_oe_nx_s = wr_nx_s;
                done_nx_s    = 1'b1;
                err_nx_s     = timeout_s;
            end
            ST_DMA: begin
                addr_oe_nx_s = 1'b0;
                dma_ack_nx_s = 1'b1;
            end
            default: addr_oe_nx_s = 1'b1;
        endcase
    end

    // Output and transaction latch registers.
    always_ff @(posedge clk) begin
        if (arst) begin
            address_bus  <= 22'd0;
            mem_io       <= 1'b1;
            data_bus_out <= 8'd0;
            wr_r         <= 1'b0;
            rdata        <= 8'd0;
            rd_n         <= 1'b1;
            wr_n         <= 1'b1;
            data_oe      <= 1'b0;
            addr_oe      <= 1'b1;
            dma_ack      <= 1'b0;
            cpu_done     <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            address_bus  <= addr_nx_s;
            mem_io       <= mem_io_nx_s;
            data_bus_out <= dout_nx_s;
            wr_r         <= wr_nx_s;
            rdata        <= rdata_nx_s;
            rd_n         <= rd_n_nx_s;
            wr_n         <= wr_n_nx_s;
            data_oe      <= data_oe_nx_s;
            addr_oe      <= addr_oe_nx_s;
            dma_ack      <= dma_ack_nx_s;
            cpu_done     <= done_nx_s;
            bus_err      <= err_nx_s;
        end
    end
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: directed bus-cycle scenarios with literal
// expectations, then random traffic checked every cycle against a timeline model.
module tb_bus_cycle_sequencer;
    localparam int SETUP_C   = 1;
    localparam int STROBE_C  = 2;
    localparam int TIMEOUT_C = 4;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_mem_io = 1'b1;
    logic [21:0] cpu_addr = 22'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic        cpu_halt = 1'b0;
    logic        dma_req = 1'b0;
    logic        pin_wait = 1'b0;
    logic [7:0]  data_bus_in = 8'd0;
    logic [21:0] address_bus;
    logic        mem_io, rd_n, wr_n, data_oe, addr_oe, dma_ack, cpu_done, bus_err;
    logic [7:0]  data_bus_out, rdata;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    // Model: a transaction is described by its age (cycles since acceptance)
    // and the age at which its hold/done cycle falls, once that is known.
    logic        m_busy = 1'b0, m_dma = 1'b0, m_wr = 1'b0, m_err = 1'b0;
    int          m_t = 0, m_hold_t = 0, m_waits = 0;
    logic [21:0] e_addr = 22'd0;
    logic [7:0]  e_dout = 8'd0, e_rdata = 8'd0;
    logic        e_mi = 1'b1, e_rd_n = 1'b1, e_wr_n = 1'b1, e_doe = 1'b0, e_aoe = 1'b1;
    logic        e_ack = 1'b0, e_done = 1'b0, e_err = 1'b0;

    bus_cycle_sequencer #(
        .SETUP_CYCLES (SETUP_C),
        .STROBE_CYCLES(STROBE_C),
        .WAIT_TIMEOUT (TIMEOUT_C)
    ) dut (
        .clk(clk), .arst(arst), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_mem_io(cpu_mem_io), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_halt(cpu_halt), .dma_req(dma_req), .pin_wait(pin_wait),
        .data_bus_in(data_bus_in), .address_bus(address_bus), .mem_io(mem_io),
        .rd_n(rd_n), .wr_n(wr_n), .data_bus_out(data_bus_out), .data_oe(data_oe),
        .addr_oe(addr_oe), .dma_ack(dma_ack), .rdata(rdata), .cpu_done(cpu_done),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  n;
        logic strobe;
        if (arst) begin
            m_busy = 1'b0; m_dma = 1'b0; m_wr = 1'b0; m_err = 1'b0;
            e_addr = 22'd0; e_mi = 1'b1; e_dout = 8'd0; e_rdata = 8'd0; e_aoe = 1'b1;
        end else if (m_dma) begin
            if (!dma_req) begin
                m_dma = 1'b0;
                e_aoe = !cpu_halt;
            end
        end else if (m_busy) begin
            if (m_t == m_hold_t) begin
                m_busy = 1'b0;
                e_aoe  = !cpu_halt;
            end else begin
                if (m_t > SETUP_C) begin
                    n = m_t - SETUP_C;
                    if (n >= STROBE_C) begin
                        if (!pin_wait) begin
                            m_hold_t = m_t + 1;
                            if (!m_wr) e_rdata = data_bus_in;
                        end else if (m_waits == TIMEOUT_C) begin
                            m_hold_t = m_t + 1;
                            m_err = 1'b1;
                            if (!m_wr) e_rdata = 8'hFF;
                        end else begin
                            m_waits++;
                        end
                    end
                end
                m_t++;
            end
        end else if (dma_req) begin
            m_dma = 1'b1;
            e_aoe = 1'b0;
        end else if (cpu_req) begin
            m_busy = 1'b1; m_t = 1; m_hold_t = 0; m_waits = 0; m_err = 1'b0;
            m_wr = cpu_wr; e_mi = cpu_mem_io; e_addr = cpu_addr; e_dout = cpu_wdata;
            e_aoe = 1'b1;
        end else begin
            e_aoe = !cpu_halt;
        end
        e_ack = m_dma;
        if (m_busy) begin
            e_done = (m_t == m_hold_t);
            e_err  = e_done && m_err;
            strobe = (m_t > SETUP_C) && !e_done;
            e_rd_n = !(strobe && !m_wr);
            e_wr_n = !(strobe && m_wr);
            e_doe  = m_wr;
        end else begin
            e_done = 1'b0; e_err = 1'b0; e_rd_n = 1'b1; e_wr_n = 1'b1; e_doe = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("address_bus", 32'(address_bus), 32'(e_addr));
            check("mem_io", 32'(mem_io), 32'(e_mi));
            check("rd_n", 32'(rd_n), 32'(e_rd_n));
            check("wr_n", 32'(wr_n), 32'(e_wr_n));
            check("data_bus_out", 32'(data_bus_out), 32'(e_dout));
            check("data_oe", 32'(data_oe), 32'(e_doe));
            check("addr_oe", 32'(addr_oe), 32'(e_aoe));
            check("dma_ack", 32'(dma_ack), 32'(e_ack));
            check("rdata", 32'(rdata), 32'(e_rdata));
            check("cpu_done", 32'(cpu_done), 32'(e_done));
            check("bus_err", 32'(bus_err), 32'(e_err));
        end
    end

    // One CPU cycle from an idle bus; cycle c is the period ending at edge c,
    // pin_wait is high for cycles w_from..w_to.
    task automatic run_txn(input logic wr, input logic mi, input logic [21:0] a,
                           input logic [7:0] wd, input logic [7:0] din,
                           input int w_from, input int w_to,
                           output int done_at, output int rd_first, output int rdl,
                           output int wrl, output int oel, output logic mi1,
                           output logic err, output logic [7:0] rd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_mem_io = mi; cpu_addr = a; cpu_wdata = wd;
        data_bus_in = din; pin_wait = 1'b0;
        done_at = -1; rd_first = -1; rdl = 0; wrl = 0; oel = 0; mi1 = 1'bx;
        err = 1'b0; rd = 8'h00;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!rd_n) begin
                rdl++;
                if (rd_first < 0) rd_first = c;
            end
            if (!wr_n) wrl++;
            if (data_oe) oel++;
            if (c == 1) mi1 = mem_io;
            if (cpu_done) begin
                done_at = c; err = bus_err; rd = rdata;
                cpu_req = 1'b0; pin_wait = 1'b0;
                break;
            end
            pin_wait = (c >= w_from) && (c <= w_to);
        end
        cpu_req = 1'b0;
        pin_wait = 1'b0;
    endtask

    initial begin
        int done_at, rd_first, rdl, wrl, oel, pw_prob;
        logic mi1, err;
        logic [7:0] rd;
        logic seen;

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_address_bus", 32'(address_bus), 32'h0);
        check("rst_mem_io", 32'(mem_io), 32'h1);
        check("rst_strobes", 32'({rd_n, wr_n}), 32'h3);
        check("rst_oe", 32'({addr_oe, data_oe, dma_ack}), 32'h4);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_done", 32'({cpu_done, bus_err}), 32'h0);
        arst = 1'b0;

        run_txn(1'b0, 1'b1, 22'h012345, 8'h00, 8'hA5, 0, -1, done_at, rd_first, rdl, wrl, oel, mi1, err, rd);
        check("rd_done_cycle", 32'(done_at), 32'd4);
        check("rd_strobe_first", 32'(rd_first), 32'd2);
        check("rd_strobe_len", 32'(rdl), 32'd2);
        check("rd_no_wr_n", 32'(wrl), 32'd0);
        check("rd_rdata", 32'(rd), 32'hA5);

        run_txn(1'b1, 1'b0, 22'h0000F0, 8'h3C, 8'h00, 0, -1, done_at, rd_first, rdl, wrl, oel, mi1, err, rd);
        check("wr_done_cycle", 32'(done_at), 32'd4);
        check("wr_mem_io", 32'(mi1), 32'h0);
        check("wr_data_oe_len", 32'(oel), 32'd4);
        check("wr_strobe_len", 32'(wrl), 32'd2);
        check("wr_data_out", 32'(data_bus_out), 32'h3C);

        run_txn(1'b0, 1'b1, 22'h000100, 8'h00, 8'h77, 3, 5, done_at, rd_first, rdl, wrl, oel, mi1, err, rd);
        check("wait_strobe_len", 32'(rdl), 32'd5);
        check("wait_done_cycle", 32'(done_at), 32'd7);
        check("wait_no_err", 32'(err), 32'h0);
        check("wait_rdata", 32'(rd), 32'h77);

        run_txn(1'b0, 1'b1, 22'h000200, 8'h00, 8'h12, 3, 1000, done_at, rd_first, rdl, wrl, oel, mi1, err, rd);
        check("tmo_strobe_len", 32'(rdl), 32'd6);
        check("tmo_done_cycle", 32'(done_at), 32'd8);
        check("tmo_bus_err", 32'(err), 32'h1);
        check("tmo_rdata", 32'(rd), 32'hFF);

        // DMA and CPU requests together: DMA first, CPU cycle after release.
        @(negedge clk);
        dma_req = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_mem_io = 1'b1;
        cpu_addr = 22'h3FFFFF; data_bus_in = 8'h5A;
        @(negedge clk);
        check("dma_ack_grant", 32'({dma_ack, addr_oe, rd_n}), 32'h5);
        repeat (2) @(negedge clk);
        check("dma_ack_hold", 32'({dma_ack, addr_oe, data_oe}), 32'h4);
        dma_req = 1'b0;
        @(negedge clk);
        check("dma_release", 32'({dma_ack, addr_oe}), 32'h1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cpu_done) begin
                seen = 1'b1;
                check("dma_cpu_rdata", 32'(rdata), 32'h5A);
                check("dma_cpu_addr", 32'(address_bus), 32'h3FFFFF);
            end
        end
        check("dma_cpu_done_seen", 32'(seen), 32'h1);
        cpu_req = 1'b0;

        // Reset in the middle of a strobe.
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 22'h000055; data_bus_in = 8'h99;
        repeat (2) @(negedge clk);
        check("mid_strobe_rd_n", 32'(rd_n), 32'h0);
        arst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check("arst_abort", 32'({rd_n, cpu_done, addr_oe, dma_ack}), 32'hA);
        arst = 1'b0;
        run_txn(1'b0, 1'b1, 22'h000ABC, 8'h00, 8'h11, 0, -1, done_at, rd_first, rdl, wrl, oel, mi1, err, rd);
        check("post_rst_done_cycle", 32'(done_at), 32'd4);
        check("post_rst_rdata", 32'(rd), 32'h11);

        // Random traffic: back-to-back cycles, waits, timeouts, DMA, halt, resets.
        pw_prob = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (cpu_req && cpu_done) begin
                if ($urandom_range(0, 2) == 0) begin
                    cpu_wr = 1'($urandom_range(0, 1)); cpu_mem_io = 1'($urandom_range(0, 1));
                    cpu_addr = 22'($urandom); cpu_wdata = 8'($urandom);
                    pw_prob = $urandom_range(0, 90);
                end else begin
                    cpu_req = 1'b0;
                end
            end else if (!cpu_req && ($urandom_range(0, 3) == 0)) begin
                cpu_req = 1'b1;
                cpu_wr = 1'($urandom_range(0, 1)); cpu_mem_io = 1'($urandom_range(0, 1));
                cpu_addr = 22'($urandom); cpu_wdata = 8'($urandom);
                pw_prob = $urandom_range(0, 90);
            end
            pin_wait = ($urandom_range(0, 99) < pw_prob);
            data_bus_in = 8'($urandom);
            if (dma_req) dma_req = ($urandom_range(0, 3) != 0);
            else dma_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) cpu_halt = ~cpu_halt;
            arst = ($urandom_range(0, 699) == 0);
        end
        cpu_req = 1'b0; dma_req = 1'b0; pin_wait = 1'b0; arst = 1'b0; cpu_halt = 1'b0;
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
